// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, transmitter and BaudGenerator users.
// Optional build macro: UART_RX_PARITY_EN adds the PARITY state to the receiver FSM.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-level result bus of the UART receiver: recovered data plus status strobes.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
);

  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;

  modport master (output data, valid, frame_err, parity_err, busy);
  modport slave  (input  data, valid, frame_err, parity_err, busy);

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops to settle metastability.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x-oversampled, LSB-first frame recovery with one-cycle result strobes.
// Optional build macro: UART_RX_PARITY_EN inserts a parity bit check before the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      baud_tick,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  // Reject parameter sets the datapath is not built for.
  if (DATA_BITS < 5 || DATA_BITS > 8 || OVERSAMPLE < 8 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: unsupported parameter set");
  end

  uart_rx_state_t       state;
  logic                 rx_s;
  logic                 rx_d;
  logic [TW-1:0]        tcnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 busy_q;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad;
  logic                 parity_err_q;
`endif

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Delayed copy of the synchronized line for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) rx_d <= 1'b1;
    else     rx_d <= rx_s;
  end

  // Frame FSM: tick counting, bit sampling and registered result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Free-running tick count while a frame is in flight; clears below override it.
      if (state != ST_IDLE && baud_tick) tcnt <= tcnt + TW'(1);

      unique case (state)
        ST_IDLE: begin
          // Only a fresh high-to-low transition starts a frame, never a held-low line.
          if (rx_d && !rx_s) begin
            tcnt   <= '0;
            busy_q <= 1'b1;
            state  <= ST_START;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        ST_START: begin
          if (baud_tick && tcnt == T_MID) begin
            if (!rx_s) begin
              tcnt  <= '0;
              bcnt  <= '0;
              state <= ST_DATA;
            end else begin
              busy_q <= 1'b0;
              state  <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (baud_tick && tcnt == T_END) begin
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            bcnt  <= bcnt + BW'(1);
            if (bcnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick && tcnt == T_END) begin
            par_bad <= rx_s != ((^shreg) ^ 1'(PARITY_ODD));
            state   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          // Leave mid stop bit so a back-to-back start edge is still caught.
          if (baud_tick && tcnt == T_END) begin
            if (rx_s) begin
              data_q  <= shreg;
              valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad;
`endif
            end else begin
              frame_err_q <= 1'b1;
            end
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
